// File: rtl/sap_pkg.sv
// Shared definitions for the memory access controller: FSM encoding,
// default bus widths and the read-latency counter helper.
package sap_pkg;

    // Default memory address and data widths.
    localparam int AW_DEFAULT = 16;
    localparam int DW_DEFAULT = 16;

    // Width of the read-latency down-counter; RD_LAT never exceeds 3.
    localparam int CNT_W = 2;

    // Requester indices on the two-way arbiter.
    localparam int REQ_F = 0;
    localparam int REQ_D = 1;

    // Controller FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Value loaded into the WAIT counter so that WAIT lasts rd_lat cycles.
    // Out-of-range latencies are clamped into 1..3.
    function automatic logic [CNT_W-1:0] rd_wait_load(input int rd_lat);
        int lat;
        lat = rd_lat;
        if (lat < 1) begin
            lat = 1;
        end
        if (lat > 3) begin
            lat = 3;
        end
        return CNT_W'(lat - 1);
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/acknowledge and RAM-side bus bundle for mem_access_ctrl.
// The slave modport is the controller's view; master is the environment.
interface mem_access_ctrl_if
    import sap_pkg::*;
#(
    parameter int AW = AW_DEFAULT,
    parameter int DW = DW_DEFAULT
);

    // Instruction-fetch requester.
    logic          f_req;
    logic [AW-1:0] f_addr;
    logic          f_ack;

    // Data requester.
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_ack;

    // MAR / RAM side.
    logic          mar_write;
    logic [AW-1:0] mar_bus;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    // Result and status.
    logic [DW-1:0] rdata;
    logic          busy;

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_addr, d_wdata,
        input  ram_rdata,
        output f_ack, d_ack,
        output mar_write, mar_bus,
        output ram_we, ram_wdata,
        output rdata, busy
    );

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_addr, d_wdata,
        output ram_rdata,
        input  f_ack, d_ack,
        input  mar_write, mar_bus,
        input  ram_we, ram_wdata,
        input  rdata, busy
    );

endinterface

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter with a last-grant flop. On a tie the
// requester that was not granted last wins; after reset fetch wins.
module mem_rr_arb2
    import sap_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       gnt_vld
);

    // 1 = data was granted last, 0 = fetch was granted last.
    logic last_d_q;

    // Pick the winner; only a single one-hot grant when enabled.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_d_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        if (!en) begin
            gnt = 2'b00;
        end
        gnt_vld = gnt[REQ_F] | gnt[REQ_D];
    end

    // Remember who won so the next tie goes to the other requester.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_d_q <= 1'b1;
        end else if (gnt_vld) begin
            last_d_q <= gnt[REQ_D];
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch and data requesters onto a
// single MAR-addressed RAM. Each transaction runs IDLE -> LOAD -> WAIT ->
// RESP using fields captured at grant time.
module mem_access_ctrl
    import sap_pkg::*;
#(
    parameter int AW     = AW_DEFAULT,
    parameter int DW     = DW_DEFAULT,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = rd_wait_load(RD_LAT);

    state_t           state_q;
    state_t           state_d;

    // Transaction fields frozen at grant.
    logic [AW-1:0]    cap_addr_q;
    logic [DW-1:0]    cap_wdata_q;
    logic             cap_we_q;
    logic             cap_dsel_q;

    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    rdata_q;

    logic [1:0]       req;
    logic [1:0]       gnt;
    logic             gnt_vld;
    logic             grant_now;
    logic             rd_last;

    assign req[REQ_F] = bus.f_req;
    assign req[REQ_D] = bus.d_req;

    mem_rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .en      (state_q == ST_IDLE),
        .gnt     (gnt),
        .gnt_vld (gnt_vld)
    );

    assign grant_now = (state_q == ST_IDLE) && gnt_vld;
    assign rd_last   = (state_q == ST_WAIT) && !cap_we_q && (cnt_q == '0);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode; outputs depend only on state and
    // captured fields so late input changes cannot disturb a transaction.
    always_comb begin
        state_d       = state_q;
        bus.mar_write = 1'b0;
        bus.mar_bus   = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        bus.f_ack     = 1'b0;
        bus.d_ack     = 1'b0;
        bus.busy      = (state_q != ST_IDLE);
        bus.rdata     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                bus.mar_write = 1'b1;
                bus.mar_bus   = cap_addr_q;
                state_d       = ST_WAIT;
            end
            ST_WAIT: begin
                if (cap_we_q) begin
                    bus.ram_we    = 1'b1;
                    bus.ram_wdata = cap_wdata_q;
                    state_d       = ST_RESP;
                end else if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.f_ack = !cap_dsel_q;
                bus.d_ack = cap_dsel_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's address, direction and write data at grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_we_q    <= 1'b0;
            cap_dsel_q  <= 1'b0;
        end else if (grant_now) begin
            cap_dsel_q  <= gnt[REQ_D];
            cap_addr_q  <= gnt[REQ_F] ? bus.f_addr : bus.d_addr;
            cap_we_q    <= gnt[REQ_D] & bus.d_we;
            cap_wdata_q <= gnt[REQ_D] ? bus.d_wdata : '0;
        end
    end

    // Read-latency down-counter: loaded in LOAD, counts through WAIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (state_q == ST_LOAD) begin
            cnt_q <= CNT_LOAD;
        end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Read result register; only the final WAIT cycle of a read updates it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (rd_last) begin
            rdata_q <= bus.ram_rdata;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with two instances (RD_LAT=1 and 3),
// each attached to a behavioural MAR + RAM model.
module tb_mem_access_ctrl;

    logic clk;
    logic rst;

    int pass_cnt;
    int total_cnt;

    mem_access_ctrl_if #(.AW(16), .DW(16)) if1 ();
    mem_access_ctrl_if #(.AW(16), .DW(16)) if3 ();

    mem_access_ctrl #(.AW(16), .DW(16), .RD_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    mem_access_ctrl #(.AW(16), .DW(16), .RD_LAT(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (if3)
    );

    // RAM models: MAR register, write port, preload port.
    logic [15:0] mem1 [65536];
    logic [15:0] mem3 [65536];
    logic [15:0] mar1_q;
    logic [15:0] mar3_q;
    logic        pk_en;
    logic        pk_sel3;
    logic [15:0] pk_addr;
    logic [15:0] pk_data;

    always @(posedge clk) begin
        if (if1.mar_write) mar1_q <= if1.mar_bus;
        if (if1.ram_we) mem1[mar1_q] <= if1.ram_wdata;
        else if (pk_en && !pk_sel3) mem1[pk_addr] <= pk_data;
    end

    always @(posedge clk) begin
        if (if3.mar_write) mar3_q <= if3.mar_bus;
        if (if3.ram_we) mem3[mar3_q] <= if3.ram_wdata;
        else if (pk_en && pk_sel3) mem3[pk_addr] <= pk_data;
    end

    assign if1.ram_rdata = mem1[mar1_q];
    assign if3.ram_rdata = mem3[mar3_q];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic sel3, input logic [15:0] a, input logic [15:0] d);
        pk_en   = 1'b1;
        pk_sel3 = sel3;
        pk_addr = a;
        pk_data = d;
        tick();
        pk_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        total_cnt++;
        if ({if1.f_ack, if1.d_ack, if1.mar_write, if1.ram_we, if1.busy} !== 5'b0)
            $display("FAIL reset_ctrl1: got %b required 00000",
                     {if1.f_ack, if1.d_ack, if1.mar_write, if1.ram_we, if1.busy});
        else pass_cnt++;
        total_cnt++;
        if ({if1.mar_bus, if1.ram_wdata, if1.rdata} !== 48'h0)
            $display("FAIL reset_data1: got %h required 0",
                     {if1.mar_bus, if1.ram_wdata, if1.rdata});
        else pass_cnt++;
        total_cnt++;
        if ({if3.f_ack, if3.d_ack, if3.mar_write, if3.ram_we, if3.busy, if3.rdata} !== 21'h0)
            $display("FAIL reset_all3: got %h required 0",
                     {if3.f_ack, if3.d_ack, if3.mar_write, if3.ram_we, if3.busy, if3.rdata});
        else pass_cnt++;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch_read();
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0010;
        tick();
        if1.f_req = 1'b0;
        total_cnt++;
        if (if1.mar_write !== 1'b1 || if1.mar_bus !== 16'h0010 || if1.busy !== 1'b1)
            $display("FAIL fetch_load: mar_write=%b mar_bus=%h busy=%b required 1 0010 1",
                     if1.mar_write, if1.mar_bus, if1.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.f_ack !== 1'b0 || if1.mar_bus !== 16'h0 || if1.mar_write !== 1'b0)
            $display("FAIL fetch_wait: f_ack=%b mar_bus=%h mar_write=%b required 0 0000 0",
                     if1.f_ack, if1.mar_bus, if1.mar_write);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.f_ack !== 1'b1 || if1.d_ack !== 1'b0 || if1.rdata !== 16'hA5A5)
            $display("FAIL fetch_ack: f_ack=%b d_ack=%b rdata=%h required 1 0 a5a5",
                     if1.f_ack, if1.d_ack, if1.rdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.f_ack !== 1'b0 || if1.busy !== 1'b0)
            $display("FAIL fetch_idle: f_ack=%b busy=%b required 0 0", if1.f_ack, if1.busy);
        else pass_cnt++;
    endtask

    task automatic test_data_write();
        if1.d_req   = 1'b1;
        if1.d_we    = 1'b1;
        if1.d_addr  = 16'h0200;
        if1.d_wdata = 16'h1234;
        tick();
        if1.d_req = 1'b0;
        total_cnt++;
        if (if1.mar_bus !== 16'h0200 || if1.ram_we !== 1'b0 || if1.ram_wdata !== 16'h0)
            $display("FAIL write_load: mar_bus=%h ram_we=%b ram_wdata=%h required 0200 0 0000",
                     if1.mar_bus, if1.ram_we, if1.ram_wdata);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.ram_we !== 1'b1 || if1.ram_wdata !== 16'h1234 || if1.d_ack !== 1'b0)
            $display("FAIL write_strobe: ram_we=%b ram_wdata=%h d_ack=%b required 1 1234 0",
                     if1.ram_we, if1.ram_wdata, if1.d_ack);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.d_ack !== 1'b1 || if1.f_ack !== 1'b0 || if1.ram_we !== 1'b0 ||
            if1.ram_wdata !== 16'h0 || if1.rdata !== 16'hA5A5)
            $display("FAIL write_ack: d_ack=%b f_ack=%b ram_we=%b ram_wdata=%h rdata=%h required 1 0 0 0000 a5a5",
                     if1.d_ack, if1.f_ack, if1.ram_we, if1.ram_wdata, if1.rdata);
        else pass_cnt++;
        if1.d_we = 1'b0;
        tick();
        // Read the location back to confirm the write landed.
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0200;
        tick();
        if1.f_req = 1'b0;
        tick();
        tick();
        total_cnt++;
        if (if1.f_ack !== 1'b1 || if1.rdata !== 16'h1234)
            $display("FAIL write_readback: f_ack=%b rdata=%h required 1 1234", if1.f_ack, if1.rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_capture_hold();
        if1.d_req  = 1'b1;
        if1.d_we   = 1'b0;
        if1.d_addr = 16'h0004;
        tick();
        if1.d_req   = 1'b0;
        if1.d_addr  = 16'h0008;
        if1.d_we    = 1'b1;
        if1.d_wdata = 16'hFFFF;
        #1;
        total_cnt++;
        if (if1.mar_write !== 1'b1 || if1.mar_bus !== 16'h0004)
            $display("FAIL hold_mar: mar_write=%b mar_bus=%h required 1 0004", if1.mar_write, if1.mar_bus);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.ram_we !== 1'b0)
            $display("FAIL hold_no_write: ram_we=%b required 0", if1.ram_we);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if1.d_ack !== 1'b1 || if1.rdata !== 16'h1111)
            $display("FAIL hold_ack: d_ack=%b rdata=%h required 1 1111", if1.d_ack, if1.rdata);
        else pass_cnt++;
        if1.d_we = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        int          n_ack;
        int          overlaps;
        int          ack_cyc [4];
        logic        ack_d   [4];
        logic [15:0] ack_rd  [4];
        n_ack    = 0;
        overlaps = 0;
        rst = 1'b0;
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0010;
        if1.d_req  = 1'b1;
        if1.d_we   = 1'b0;
        if1.d_addr = 16'h0004;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 40 && n_ack < 4; c++) begin
            tick();
            if (if1.f_ack && if1.d_ack) overlaps++;
            if (if1.f_ack || if1.d_ack) begin
                ack_cyc[n_ack] = c;
                ack_d[n_ack]   = if1.d_ack;
                ack_rd[n_ack]  = if1.rdata;
                n_ack++;
            end
        end
        if1.f_req = 1'b0;
        if1.d_req = 1'b0;
        total_cnt++;
        if (n_ack !== 4)
            $display("FAIL rr_ack_count: got %0d required 4 within 40 cycles", n_ack);
        else pass_cnt++;
        total_cnt++;
        if (overlaps !== 0)
            $display("FAIL rr_overlap: got %0d overlapping cycles required 0", overlaps);
        else pass_cnt++;
        for (int i = 0; i < n_ack; i++) begin
            total_cnt++;
            if (ack_d[i] !== logic'(i % 2) || ack_rd[i] !== ((i % 2) ? 16'h1111 : 16'hA5A5))
                $display("FAIL rr_order_%0d: d_ack=%b rdata=%h required %0d %h", i, ack_d[i],
                         ack_rd[i], i % 2, ((i % 2) ? 16'h1111 : 16'hA5A5));
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (ack_cyc[i] - ack_cyc[i-1] !== 4)
                    $display("FAIL rr_spacing_%0d: got %0d required 4", i, ack_cyc[i] - ack_cyc[i-1]);
                else pass_cnt++;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_back_to_back();
        int n_ack;
        int first_c;
        int second_c;
        n_ack    = 0;
        first_c  = 0;
        second_c = 0;
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0010;
        for (int c = 0; c < 20 && n_ack < 2; c++) begin
            tick();
            if (if1.f_ack) begin
                if (n_ack == 0) first_c = c;
                else second_c = c;
                n_ack++;
            end
        end
        if1.f_req = 1'b0;
        total_cnt++;
        if (n_ack !== 2 || second_c - first_c !== 4)
            $display("FAIL b2b_refetch: acks=%0d spacing=%0d required 2 4", n_ack, second_c - first_c);
        else pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_long_latency();
        if3.f_req  = 1'b1;
        if3.f_addr = 16'hFFFF;
        tick();
        if3.f_req = 1'b0;
        total_cnt++;
        if (if3.mar_write !== 1'b1 || if3.mar_bus !== 16'hFFFF)
            $display("FAIL lat3_load: mar_write=%b mar_bus=%h required 1 ffff", if3.mar_write, if3.mar_bus);
        else pass_cnt++;
        tick();
        tick();
        tick();
        total_cnt++;
        if (if3.f_ack !== 1'b0 || if3.busy !== 1'b1)
            $display("FAIL lat3_early: f_ack=%b busy=%b required 0 1", if3.f_ack, if3.busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (if3.f_ack !== 1'b1 || if3.rdata !== 16'hBEEF)
            $display("FAIL lat3_ack: f_ack=%b rdata=%h required 1 beef", if3.f_ack, if3.rdata);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_mid();
        int acks;
        acks = 0;
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0010;
        tick();
        if1.f_req = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({if1.f_ack, if1.d_ack, if1.mar_write, if1.ram_we, if1.busy} !== 5'b0 ||
            {if1.mar_bus, if1.ram_wdata, if1.rdata} !== 48'h0)
            $display("FAIL midrst_outputs: ctrl=%b data=%h required 0 0",
                     {if1.f_ack, if1.d_ack, if1.mar_write, if1.ram_we, if1.busy},
                     {if1.mar_bus, if1.ram_wdata, if1.rdata});
        else pass_cnt++;
        tick();
        if (if1.f_ack || if1.d_ack) acks++;
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (if1.f_ack || if1.d_ack) acks++;
        end
        total_cnt++;
        if (acks !== 0)
            $display("FAIL midrst_no_ack: got %0d acks required 0", acks);
        else pass_cnt++;
        if1.f_req  = 1'b1;
        if1.f_addr = 16'h0001;
        tick();
        if1.f_req = 1'b0;
        total_cnt++;
        if (if1.mar_bus !== 16'h0001)
            $display("FAIL midrst_reload: mar_bus=%h required 0001", if1.mar_bus);
        else pass_cnt++;
        tick();
        tick();
        total_cnt++;
        if (if1.f_ack !== 1'b1 || if1.rdata !== 16'h5A5A)
            $display("FAIL midrst_fetch: f_ack=%b rdata=%h required 1 5a5a", if1.f_ack, if1.rdata);
        else pass_cnt++;
        tick();
    endtask

    initial begin
        pass_cnt    = 0;
        total_cnt   = 0;
        rst         = 1'b0;
        pk_en       = 1'b0;
        pk_sel3     = 1'b0;
        pk_addr     = 16'h0;
        pk_data     = 16'h0;
        if1.f_req   = 1'b0;
        if1.f_addr  = 16'h0;
        if1.d_req   = 1'b0;
        if1.d_we    = 1'b0;
        if1.d_addr  = 16'h0;
        if1.d_wdata = 16'h0;
        if3.f_req   = 1'b0;
        if3.f_addr  = 16'h0;
        if3.d_req   = 1'b0;
        if3.d_we    = 1'b0;
        if3.d_addr  = 16'h0;
        if3.d_wdata = 16'h0;
        poke(1'b0, 16'h0010, 16'hA5A5);
        poke(1'b0, 16'h0004, 16'h1111);
        poke(1'b0, 16'h0008, 16'h2222);
        poke(1'b0, 16'h0001, 16'h5A5A);
        poke(1'b1, 16'hFFFF, 16'hBEEF);
        test_reset();
        test_fetch_read();
        test_data_write();
        test_capture_hold();
        test_round_robin();
        test_back_to_back();
        test_long_latency();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL provide parameter AW, default 16, memory address width.
REQ-002 SHALL provide parameter DW, default 16, memory data width.
REQ-003 SHALL provide parameter RD_LAT, default 1, RAM read latency in cycles after MAR load; legal range 1..3.
REQ-004 SHALL have ports:
 clk  in  1  single clock; all flops on rising edge.
 rst  in  1  asynchronous, active-low reset.
 f_req  in  1  instruction-fetch request.
 f_addr  in  AW  fetch address.
 f_ack  out  1  fetch done, 1-cycle pulse; rdata valid.
 d_req  in  1  data request.
 d_we  in  1  data direction: 1 = write, 0 = read.
 d_addr  in  AW  data address.
 d_wdata  in  DW  data write value.
 d_ack  out  1  data done, 1-cycle pulse.
 mar_write  out  1  MAR load strobe.
 mar_bus  out  AW  address driven onto the bus for the MAR.
 ram_we  out  1  RAM write strobe.
 ram_wdata  out  DW  RAM write data.
 ram_rdata  in  DW  RAM read data.
 rdata  out  DW  registered read result.
 busy  out  1  high in every state except IDLE.

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, WAIT, RESP.
REQ-006 IDLE: no request -> stay in IDLE; any request -> grant, capture the winner's addr/we/wdata, go to LOAD.
REQ-007 Arbitration, single request: grant that requester.
REQ-008 Arbitration, both requesting: grant the requester not granted last (round-robin).
REQ-009 LOAD (1 cycle): mar_write=1, mar_bus=captured addr; next state WAIT.
REQ-010 mar_bus SHALL be 0 in every state except LOAD.
REQ-011 WAIT, read: RD_LAT cycles; capture ram_rdata into rdata on the last WAIT cycle; next state RESP.
REQ-012 WAIT, write: exactly 1 cycle with ram_we=1 and ram_wdata=captured wdata; next state RESP.
REQ-013 ram_wdata SHALL be 0 in every cycle where ram_we=0.
REQ-014 RESP (1 cycle): assert f_ack or d_ack for the granted requester only; next state IDLE.
REQ-015 Latency, grant cycle to ack cycle = 2+RD_LAT cycles for reads and 3 for writes.
REQ-016 Captured fields SHALL be used for the whole transaction; input changes or req deassertion after grant SHALL NOT abort or alter it, and the ack SHALL still pulse.
REQ-017 A requester still asserting req in the cycle after its ack is treated as a new request.
REQ-018 rdata SHALL hold its value until the next read capture; writes SHALL NOT modify it.
REQ-019 f_ack and d_ack SHALL never be high in the same cycle.

Reset
REQ-020 While rst=0, SHALL force: state=IDLE, last-grant=data (fetch wins the first tie), all outputs 0, captured registers 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction and issue no ack; after release, operation restarts from IDLE.

Structure
REQ-022 Shared package sap_pkg SHALL hold the FSM state encoding and the AW/DW defaults.
REQ-023 Round-robin selection SHALL be a sub-module mem_rr_arb2 (2 requests, grant-valid strobe, last-grant flop).
REQ-024 The RD_LAT down-counter SHALL reside in mem_access_ctrl.

Verification
REQ-025 Fetch read, f_addr=16'h0010, RAM[0x10]=16'hA5A5, RD_LAT=1 -> mar_write with mar_bus=16'h0010 at grant+1; f_ack at grant+3; rdata=16'hA5A5.
REQ-026 Data write, d_addr=16'h0200, d_wdata=16'h1234 -> ram_we=1 for one cycle at grant+2 with ram_wdata=16'h1234; d_ack at grant+3; rdata unchanged.
REQ-027 f_req and d_req high continuously from reset release -> grants alternate F,D,F,D; acks never overlap.
REQ-028 RD_LAT=3 read of address 16'hFFFF -> ack at grant+5; rdata equals RAM[0xFFFF].
REQ-029 rst pulled low during WAIT -> all outputs 0 immediately; no ack; after release, a fresh fetch to 16'h0001 completes normally.
REQ-030 d_addr changed from 16'h0004 to 16'h0008 after grant -> MAR is still loaded with 16'h0004.
